// File: rtl/vram_pkg.sv
// Shared types and geometry for the vram rectangle-fill engine.
// Optional boot-time clear is enabled with VRAM_RECT_FILL_BOOTCLR_EN.
package vram_pkg;

  localparam int FB_W   = 256;
  localparam int FB_H   = 256;
  localparam int ADDR_W = 16;
  localparam int PIX_W  = 24;
  localparam int XW     = $clog2(FB_W);
  localparam int CW     = 10;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [CW-1:0]    ext_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [8:0] h;
    pixel_t     color;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FIN,
    CLR
  } fill_state_t;

  function automatic ext_t clip_len(
    input logic [8:0] len,
    input ext_t       room
  );
    ext_t l;
    l = ext_t'(len);
    return (l < room) ? l : room;
  endfunction

endpackage

// File: rtl/rect_clip.sv
// Clips a requested rectangle extent against the framebuffer edge.
// Widened to 10 bits so FB_W - x never wraps.
module rect_clip
  import vram_pkg::*;
(
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [8:0] w,
  input  logic [8:0] h,
  output ext_t       wc,
  output ext_t       hc,
  output logic       empty
);

  ext_t room_x;
  ext_t room_y;

  assign room_x = ext_t'(FB_W) - ext_t'(x);
  assign room_y = ext_t'(FB_H) - ext_t'(y);

  assign wc = clip_len(w, room_x);
  assign hc = clip_len(h, room_y);

  assign empty = (wc == '0) || (hc == '0);

endmodule

// File: rtl/vram_rect_fill.sv
// Rectangle-fill engine driving the vram write port, one pixel/clock.
// Define VRAM_RECT_FILL_BOOTCLR_EN to zero the framebuffer after reset.
module vram_rect_fill
  import vram_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [8:0]        cmd_h,
  input  logic [PIX_W-1:0]  cmd_color,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  dout,
  output logic              writeEnable,
  output logic              busy,
  output logic              done
);

`ifdef VRAM_RECT_FILL_BOOTCLR_EN
  localparam fill_state_t RST_STATE = CLR;
`else
  localparam fill_state_t RST_STATE = IDLE;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(FB_W * FB_H - 1);

  fill_state_t state_q, state_d;

  rect_cmd_t cmd;
  ext_t      wc, hc;
  logic      empty;

  ext_t wc_q, wc_d;
  ext_t hc_q, hc_d;
  ext_t cx_q, cx_d;
  ext_t cy_q, cy_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] row_step;
  pixel_t            dout_q, dout_d;

  logic we_q, we_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic row_end;
  logic last_pix;

  assign cmd = '{
    x:     cmd_x,
    y:     cmd_y,
    w:     cmd_w,
    h:     cmd_h,
    color: cmd_color
  };

  rect_clip u_clip (
    .x     (cmd.x),
    .y     (cmd.y),
    .w     (cmd.w),
    .h     (cmd.h),
    .wc    (wc),
    .hc    (hc),
    .empty (empty)
  );

  assign start_addr =
    (ADDR_W'(cmd.y) << XW) | ADDR_W'(cmd.x);

  // Jump from the last column of a row to x0 of the next row.
  assign row_step =
    ADDR_W'(FB_W) - ADDR_W'(wc_q) + ADDR_W'(1);

  assign row_end  = (cx_q == wc_q - ext_t'(1));
  assign last_pix = row_end && (cy_q == hc_q - ext_t'(1));

  always_comb begin
    state_d   = state_q;
    wc_d      = wc_q;
    hc_d      = hc_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    cmd_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          wc_d    = wc;
          hc_d    = hc;
          cx_d    = '0;
          cy_d    = '0;
          addr_d  = start_addr;
          dout_d  = cmd.color;
          state_d = empty ? FIN : FILL;
        end
      end
      FILL: begin
        if (last_pix) begin
          state_d = FIN;
        end else if (row_end) begin
          cx_d   = '0;
          cy_d   = cy_q + ext_t'(1);
          addr_d = addr_q + row_step;
        end else begin
          cx_d   = cx_q + ext_t'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
`ifdef VRAM_RECT_FILL_BOOTCLR_EN
      CLR: begin
        dout_d = '0;
        // First CLR cycle only arms the strobe so address 0 is written.
        if (!we_q) begin
          addr_d = '0;
        end else if (addr_q == LAST_ADDR) begin
          state_d = FIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    we_d   = (state_d == FILL) || (state_d == CLR);
    busy_d = we_d;
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wc_q   <= '0;
      hc_q   <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      addr_q <= '0;
      dout_q <= '0;
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wc_q   <= wc_d;
      hc_q   <= hc_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      we_q   <= we_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign addr        = addr_q;
  assign dout        = dout_q;
  assign writeEnable = we_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
